// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: writeback source encoding and common widths.
package riscv_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam logic [4:0]  REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2,
        RES_IMM = 2'd3
    } result_sel_t;

endpackage

// File: rtl/wb_result_mux.sv
// Four-way writeback source select; purely combinational so the forwarding
// unit can reuse it on its own operands.
module wb_result_mux
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [1:0]      sel,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] mem_data,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = '0;
        case (result_sel_t'(sel))
            RES_ALU: result = alu_result;
            RES_MEM: result = mem_data;
            RES_PC4: result = pc_plus4;
            RES_IMM: result = imm;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback: stall/flush handling, register-file
// write port and forwarding value. Define RETIRE_CNT_EN for the 64-bit instret counter.
module mem_wb_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEF,
    parameter int unsigned RF_ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_WB,
    input  logic                 flush_MEM,
    input  logic                 valid_MEM,
    input  logic                 reg_write_MEM,
    input  logic [1:0]           result_sel_MEM,
    input  logic [RF_ADDR_W-1:0] rd_MEM,
    input  logic [XLEN-1:0]      alu_result_MEM,
    input  logic [XLEN-1:0]      mem_data_MEM,
    input  logic [XLEN-1:0]      pc_plus4_MEM,
    input  logic [XLEN-1:0]      imm_MEM,
    output logic                 valid_WB,
    output logic                 rf_we_WB,
    output logic [RF_ADDR_W-1:0] rf_waddr_WB,
    output logic [XLEN-1:0]      rf_wdata_WB,
    output logic                 retire_WB,
    output logic [63:0]          instret_WB
);

    logic                 valid_q;
    logic                 reg_write_q;
    result_sel_t          result_sel_q;
    logic [RF_ADDR_W-1:0] rd_q;
    logic [XLEN-1:0]      alu_result_q;
    logic [XLEN-1:0]      mem_data_q;
    logic [XLEN-1:0]      pc_plus4_q;
    logic [XLEN-1:0]      imm_q;

    // Stall outranks flush so a held instruction is never lost to a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            result_sel_q <= RES_ALU;
            rd_q         <= '0;
            alu_result_q <= '0;
            mem_data_q   <= '0;
            pc_plus4_q   <= '0;
            imm_q        <= '0;
        end else if (stall_WB) begin
            valid_q      <= valid_q;
            reg_write_q  <= reg_write_q;
            result_sel_q <= result_sel_q;
            rd_q         <= rd_q;
            alu_result_q <= alu_result_q;
            mem_data_q   <= mem_data_q;
            pc_plus4_q   <= pc_plus4_q;
            imm_q        <= imm_q;
        end else if (flush_MEM) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            result_sel_q <= RES_ALU;
            rd_q         <= '0;
            alu_result_q <= '0;
            mem_data_q   <= '0;
            pc_plus4_q   <= '0;
            imm_q        <= '0;
        end else begin
            valid_q      <= valid_MEM;
            reg_write_q  <= reg_write_MEM;
            result_sel_q <= result_sel_t'(result_sel_MEM);
            rd_q         <= rd_MEM;
            alu_result_q <= alu_result_MEM;
            mem_data_q   <= mem_data_MEM;
            pc_plus4_q   <= pc_plus4_MEM;
            imm_q        <= imm_MEM;
        end
    end

    wb_result_mux #(
        .XLEN(XLEN)
    ) u_result_mux (
        .sel        (result_sel_q),
        .alu_result (alu_result_q),
        .mem_data   (mem_data_q),
        .pc_plus4   (pc_plus4_q),
        .imm        (imm_q),
        .result     (rf_wdata_WB)
    );

    assign valid_WB    = valid_q;
    assign rf_waddr_WB = rd_q;
    // Gating with stall makes a held instruction commit only on its release cycle.
    assign rf_we_WB    = valid_q & reg_write_q & (rd_q != RF_ADDR_W'(REG_ZERO)) & ~stall_WB;
    assign retire_WB   = valid_q & ~stall_WB;

`ifdef RETIRE_CNT_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else if (retire_WB) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret_WB = instret_q;
`else
    assign instret_WB = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a slot-level reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        stall_WB;
    logic        flush_MEM;
    logic        valid_MEM;
    logic        reg_write_MEM;
    logic [1:0]  result_sel_MEM;
    logic [4:0]  rd_MEM;
    logic [31:0] alu_result_MEM;
    logic [31:0] mem_data_MEM;
    logic [31:0] pc_plus4_MEM;
    logic [31:0] imm_MEM;
    logic        valid_WB;
    logic        rf_we_WB;
    logic [4:0]  rf_waddr_WB;
    logic [31:0] rf_wdata_WB;
    logic        retire_WB;
    logic [63:0] instret_WB;

    mem_wb_stage #(
        .XLEN      (32),
        .RF_ADDR_W (5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_WB       (stall_WB),
        .flush_MEM      (flush_MEM),
        .valid_MEM      (valid_MEM),
        .reg_write_MEM  (reg_write_MEM),
        .result_sel_MEM (result_sel_MEM),
        .rd_MEM         (rd_MEM),
        .alu_result_MEM (alu_result_MEM),
        .mem_data_MEM   (mem_data_MEM),
        .pc_plus4_MEM   (pc_plus4_MEM),
        .imm_MEM        (imm_MEM),
        .valid_WB       (valid_WB),
        .rf_we_WB       (rf_we_WB),
        .rf_waddr_WB    (rf_waddr_WB),
        .rf_wdata_WB    (rf_wdata_WB),
        .retire_WB      (retire_WB),
        .instret_WB     (instret_WB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: the WB slot holds one instruction record with its final writeback value.
    typedef struct packed {
        logic        valid;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] wdata;
    } slot_t;

    slot_t       slot;
    logic [63:0] model_cnt;
    logic        started = 1'b0;

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] alu,
                                         input logic [31:0] mem, input logic [31:0] pc4,
                                         input logic [31:0] imm);
        if (sel == 2'd0) return alu;
        if (sel == 2'd1) return mem;
        if (sel == 2'd2) return pc4;
        return imm;
    endfunction

    always @(posedge clk) begin
        started <= 1'b1;
        if (rst) begin
            slot      <= '0;
            model_cnt <= '0;
        end else begin
            if (slot.valid && !stall_WB) model_cnt <= model_cnt + 64'd1;
            if (!stall_WB) begin
                if (flush_MEM) slot <= '0;
                else slot <= '{valid: valid_MEM, rw: reg_write_MEM, rd: rd_MEM,
                               wdata: pick(result_sel_MEM, alu_result_MEM, mem_data_MEM,
                                           pc_plus4_MEM, imm_MEM)};
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_valid", {63'd0, valid_WB}, {63'd0, slot.valid});
            chk("m_we", {63'd0, rf_we_WB},
                {63'd0, slot.valid && slot.rw && (slot.rd != 5'd0) && !stall_WB});
            chk("m_waddr", {59'd0, rf_waddr_WB}, {59'd0, slot.rd});
            chk("m_wdata", {32'd0, rf_wdata_WB}, {32'd0, slot.wdata});
            chk("m_retire", {63'd0, retire_WB}, {63'd0, slot.valid && !stall_WB});
`ifdef RETIRE_CNT_EN
            chk("m_instret", instret_WB, model_cnt);
`else
            chk("m_instret", instret_WB, 64'd0);
`endif
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] sel,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pc4, input logic [31:0] imm,
                         input logic stall, input logic flush);
        valid_MEM      = v;
        reg_write_MEM  = rw;
        result_sel_MEM = sel;
        rd_MEM         = rd;
        alu_result_MEM = alu;
        mem_data_MEM   = mem;
        pc_plus4_MEM   = pc4;
        imm_MEM        = imm;
        stall_WB       = stall;
        flush_MEM      = flush;
    endtask

    task automatic idle;
        drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk);
        chk("rst_valid", {63'd0, valid_WB}, 64'd0);
        chk("rst_wdata", {32'd0, rf_wdata_WB}, 64'd0);
        chk("rst_instret", instret_WB, 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("idle_we", {63'd0, rf_we_WB}, 64'd0);

        // Load writeback
        tick();
        drive(1'b1, 1'b1, 2'd1, 5'd5, 32'h0000_0010, 32'hFFFF_FF80, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 2'd0, 5'd6, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("load_we", {63'd0, rf_we_WB}, 64'd1);
        chk("load_waddr", {59'd0, rf_waddr_WB}, 64'd5);
        chk("load_wdata", {32'd0, rf_wdata_WB}, 64'hFFFF_FF80);
        chk("load_retire", {63'd0, retire_WB}, 64'd1);

        // Source select on consecutive cycles
        tick();
        drive(1'b1, 1'b1, 2'd2, 5'd8, 32'h0, 32'h0, 32'h0000_0108, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("sel_alu", {32'd0, rf_wdata_WB}, 64'h0000_1234);
        tick();
        drive(1'b1, 1'b1, 2'd3, 5'd9, 32'h0, 32'h0, 32'h0, 32'hABCD_E000, 1'b0, 1'b0);
        @(negedge clk);
        chk("sel_pc4", {32'd0, rf_wdata_WB}, 64'h0000_0108);
        tick();
        drive(1'b1, 1'b1, 2'd0, 5'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("sel_imm", {32'd0, rf_wdata_WB}, 64'hABCD_E000);

        // x0 suppression
        tick();
        drive(1'b1, 1'b1, 2'd0, 5'd7, 32'h0000_0042, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("x0_we", {63'd0, rf_we_WB}, 64'd0);
        chk("x0_retire", {63'd0, retire_WB}, 64'd1);
        chk("x0_wdata", {32'd0, rf_wdata_WB}, 64'hDEAD_BEEF);

        // Stall with simultaneous flush for 3 cycles
        tick();
        drive(1'b1, 1'b1, 2'd0, 5'd9, 32'h0000_0099, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
`ifdef RETIRE_CNT_EN
        force dut.instret_q = '1;
        model_cnt = '1;
        #1 release dut.instret_q;
`endif
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_wdata", {32'd0, rf_wdata_WB}, 64'h0000_0042);
            chk("stall_we", {63'd0, rf_we_WB}, 64'd0);
            chk("stall_retire", {63'd0, retire_WB}, 64'd0);
            tick();
        end
        idle();
        @(negedge clk);
        chk("rel_we", {63'd0, rf_we_WB}, 64'd1);
        chk("rel_waddr", {59'd0, rf_waddr_WB}, 64'd7);
        chk("rel_retire", {63'd0, retire_WB}, 64'd1);
        tick();
        @(negedge clk);
        chk("rel_once_we", {63'd0, rf_we_WB}, 64'd0);
        chk("rel_once_retire", {63'd0, retire_WB}, 64'd0);
`ifdef RETIRE_CNT_EN
        chk("wrap_instret", instret_WB, 64'd0);
`endif

        // Flush bubble
        tick();
        drive(1'b1, 1'b1, 2'd0, 5'd3, 32'h0000_0005, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        idle();
        @(negedge clk);
        chk("flush_valid", {63'd0, valid_WB}, 64'd0);
        chk("flush_we", {63'd0, rf_we_WB}, 64'd0);
        chk("flush_wdata", {32'd0, rf_wdata_WB}, 64'd0);

        // Reset during a stall discards the held instruction
        tick();
        drive(1'b1, 1'b1, 2'd0, 5'd10, 32'h0000_0077, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        idle();
        stall_WB = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stall_WB = 1'b0;
        @(negedge clk);
        chk("rststall_valid", {63'd0, valid_WB}, 64'd0);
        chk("rststall_we", {63'd0, rf_we_WB}, 64'd0);
        chk("rststall_retire", {63'd0, retire_WB}, 64'd0);

        tick();
        tick();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback stage of the 5-stage RISC-V core.
- Captures the memory-stage results each cycle: ALU result, load data from memory2c, PC+4, immediate, rd and control.
- Selects the writeback value and drives the register-file write port and the forwarding path.
- Handles stall and flush, and optionally counts retired instructions.

Parameters:
- XLEN, 32, datapath width.
- RF_ADDR_W, 5, register-file address width.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- stall_WB  input  1  hold the WB register contents; no commit this cycle.
- flush_MEM  input  1  replace the incoming MEM instruction with a bubble.
- valid_MEM  input  1  the MEM-stage slot holds a real instruction.
- reg_write_MEM  input  1  instruction writes rd.
- result_sel_MEM  input  2  writeback source select.
- rd_MEM  input  RF_ADDR_W  destination register.
- alu_result_MEM  input  XLEN  ALU result / effective address.
- mem_data_MEM  input  XLEN  load data, already sized and sign/zero-extended by memory2c.
- pc_plus4_MEM  input  XLEN  link value for JAL/JALR.
- imm_MEM  input  XLEN  U-type immediate for LUI.
- valid_WB  output  1  registered valid.
- rf_we_WB  output  1  register-file write enable.
- rf_waddr_WB  output  RF_ADDR_W  register-file write address.
- rf_wdata_WB  output  XLEN  register-file write data; also the forwarding value.
- retire_WB  output  1  one-cycle pulse per committed instruction.
- instret_WB  output  64  retired-instruction count (RETIRE_CNT_EN only; otherwise tied to 0).

Behaviour:
- Register update priority on each clk edge: rst > stall_WB > flush_MEM > capture.
- rst=1:
  - all WB registers clear to 0 (valid, reg_write, rd, result_sel, data fields).
  - valid_WB=0, rf_we_WB=0, rf_waddr_WB=0, rf_wdata_WB=0, retire_WB=0, instret_WB=0.
  - A reset asserted mid-stall discards the held instruction; no commit occurs.
- stall_WB=1: every WB register holds its value; flush_MEM is ignored that cycle.
- flush_MEM=1, no stall: valid and reg_write registers load 0; the data fields also load 0.
- Otherwise: all *_MEM inputs are captured into the WB registers.
- Latency: exactly one cycle from MEM inputs to WB outputs.
- result_sel encoding:
  - 0 = ALU
  - 1 = MEM
  - 2 = PC+4
  - 3 = IMM
- rf_wdata_WB is a combinational mux of the registered fields using the registered result_sel. It is valid even while stalled, so forwarding stays stable.
- rf_waddr_WB = registered rd.
- Commit: rf_we_WB = valid & reg_write & (rd != 0) & ~stall_WB.
  - x0 is never written.
  - A stalled instruction commits exactly once, in the first cycle stall_WB is low.
- retire_WB = valid & ~stall_WB. It counts bubbles-free retirement, including rd=x0, stores and branches.
- No handshake beyond stall/flush; the hazard unit owns both.
- stall_WB and flush_MEM asserted together: stall wins, and the held instruction is preserved.

Optional Feature:
- Macro RETIRE_CNT_EN.
- Defined: 64-bit instret_WB register.
  - Resets to 0 and increments by 1 on each cycle where retire_WB=1.
  - Wraps from 2^64-1 to 0.
  - Unaffected by flush.
- Undefined: no counter flops; instret_WB is driven to 0.

Decomposition:
- Shared package riscv_pkg holds:
  - the result_sel_t enum (RES_ALU=0, RES_MEM=1, RES_PC4=2, RES_IMM=3);
  - XLEN_DEF=32;
  - REG_ZERO=5'd0.
- One sub-module, wb_result_mux: purely combinational four-way select, reusable by the forwarding unit.
- The pipeline register and the optional counter stay in mem_wb_stage.

Test Plan:
- Reset, then idle: rst=1 for 2 cycles -> all outputs 0; after release with valid_MEM=0, rf_we_WB stays 0.
- Load writeback: valid=1, reg_write=1, rd=5, sel=1, mem_data=0xFFFF_FF80 -> next cycle rf_we_WB=1, rf_waddr_WB=5, rf_wdata_WB=0xFFFF_FF80, retire_WB=1.
- Source select: sel=0 with alu=0x1234, then sel=2 with pc+4=0x0000_0108, then sel=3 with imm=0xABCDE000 -> rf_wdata_WB tracks each value on consecutive cycles.
- x0 suppression: rd=0, reg_write=1, alu=0xDEAD_BEEF -> rf_we_WB=0, retire_WB=1.
- Stall with simultaneous flush: capture rd=7/alu=0x42, then stall_WB=1 and flush_MEM=1 for 3 cycles:
  - during the stall: rf_wdata_WB=0x42, rf_we_WB=0, retire_WB=0;
  - on the release cycle: rf_we_WB=1 and retire_WB=1 exactly once;
  - with RETIRE_CNT_EN, instret_WB increments by exactly 1.
- Flush bubble and counter wrap:
  - flush_MEM=1 with valid_MEM=1 -> valid_WB=0, rf_we_WB=0, instret_WB unchanged.
  - With RETIRE_CNT_EN, force instret to 2^64-1 and retire once -> instret_WB=0.
